// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, data width, minimum
// clocks-per-bit and a 2-of-3 majority helper.
package uart_rx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MIN_N  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both flops reset to 1.
module uart_sync (
    input  logic clk,
    input  logic rstb,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-cycle rx_valid / frame_err pulses.
// Define UART_RX_MAJORITY_EN to take each bit decision as a 2-of-3 vote over three cycles.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CFG_W = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [CFG_W-1:0]  baudrate_cfg,
    input  logic              rx,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_err,
    output logic              rx_busy
);

    logic              w_rx_s;
    logic              w_bit;
    logic [CFG_W-1:0]  w_n;
    logic [CFG_W-1:0]  w_half;
    logic [CFG_W-1:0]  w_half_m1;
    logic [CFG_W-1:0]  w_n_m1;

    rx_state_e         r_state, w_state_d;
    logic [CFG_W-1:0]  r_cnt, w_cnt_d;
    logic [2:0]        r_bit_cnt, w_bit_cnt_d;
    logic [DATA_W-1:0] r_shift, w_shift_d;
    logic [DATA_W-1:0] r_data, w_data_d;
    logic              r_valid, w_valid_d;
    logic              r_err, w_err_d;

    uart_sync u_sync (
        .clk  (clk),
        .rstb (rstb),
        .i_d  (rx),
        .o_q  (w_rx_s)
    );

    assign w_n       = (baudrate_cfg < CFG_W'(MIN_N)) ? CFG_W'(MIN_N) : baudrate_cfg;
    assign w_half    = w_n >> 1;
    assign w_half_m1 = w_half - CFG_W'(1);
    assign w_n_m1    = w_n - CFG_W'(1);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = maj3(w_rx_s, r_hist[0], r_hist[1]);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
            r_data    <= w_data_d;
            r_valid   <= w_valid_d;
            r_err     <= w_err_d;
        end
    end

    // r_cnt counts cycles already spent in the state, so the half-bit point is half-1
    // after entering START and every later bit falls exactly N cycles on.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt + CFG_W'(1);
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_data_d    = r_data;
        w_valid_d   = 1'b0;
        w_err_d     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (!w_rx_s) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (r_cnt == w_half_m1) begin
                    w_cnt_d     = '0;
                    w_bit_cnt_d = '0;
                    w_state_d   = w_bit ? StIdle : StData;
                end
            end
            StData: begin
                if (r_cnt == w_n_m1) begin
                    w_cnt_d              = '0;
                    w_shift_d[r_bit_cnt] = w_bit;
                    w_bit_cnt_d          = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (r_cnt == w_n_m1) begin
                    w_cnt_d = '0;
                    if (w_bit) begin
                        w_data_d  = r_shift;
                        w_valid_d = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_err_d   = 1'b1;
                        w_state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (w_rx_s) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    assign rx_valid  = r_valid;
    assign rx_data   = r_data;
    assign frame_err = r_err;
    assign rx_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: per-cycle comparison against a waveform-level receiver
// model, a table of directed frames with fixed latencies, and random back-to-back traffic.
`timescale 1ns/1ps
module tb_uart_rx;

    logic        clk;
    logic        rstb;
    logic [15:0] cfg;
    logic        rx;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_err;
    logic        rx_busy;

    uart_rx #(.CFG_W(16)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .baudrate_cfg (cfg),
        .rx           (rx),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit         line[$];
    bit         exp_valid[];
    bit         exp_err[];
    bit         exp_busy[];
    logic [7:0] exp_data[];
    bit         obs_busy[];
    logic [7:0] rx_q[$];
    logic [7:0] last_data;
    int         first_evt;
    logic [7:0] first_data;
    int         n_valid;
    int         n_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp,
                         input int at);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0d: got %0h expected %0h", name, at, got, exp);
        end
    endtask

    function automatic int n_eff(input logic [15:0] c);
        return (c < 16'd4) ? 4 : int'(c);
    endfunction

    // Line level before the waveform starts and after it ends is idle high.
    function automatic bit ln(input int i);
        if (i < 0 || i >= line.size()) return 1'b1;
        return line[i];
    endfunction

    function automatic bit smp(input int i);
`ifdef UART_RX_MAJORITY_EN
        int s;
        s = int'(ln(i - 2)) + int'(ln(i - 1)) + int'(ln(i));
        return (s >= 2);
`else
        return ln(i);
`endif
    endfunction

    task automatic push_bits(input bit v, input int cnt);
        for (int k = 0; k < cnt; k++) line.push_back(v);
    endtask

    task automatic add_frame(input int n, input logic [7:0] d, input bit stop, input bit spike);
        push_bits(1'b0, n);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < n; c++) line.push_back(d[k] ^ (spike && c == (n >> 1)));
        end
        push_bits(stop, n);
    endtask

    // Index j of every expected array is the output state after the edge that captures
    // line[j]; a line value is seen by the receiver logic two edges after capture.
    task automatic model_run(input int n, input int total);
        int half, i, s, d, st, r;
        logic [7:0] b;
        half = n >> 1;
        exp_valid = new[total];
        exp_err   = new[total];
        exp_busy  = new[total];
        exp_data  = new[total];
        foreach (exp_data[k]) exp_data[k] = last_data;
        i = 0;
        while (i < total) begin
            if (ln(i)) begin
                i++;
                continue;
            end
            s = i;
            d = s + half;
            r = d;
            if (smp(d)) begin
                r = d;
                i = d + 1;
            end else begin
                for (int k = 0; k < 8; k++) b[k] = smp(d + (k + 1) * n);
                st = d + 9 * n;
                if (smp(st)) begin
                    r = st;
                    if (st + 2 < total) begin
                        exp_valid[st + 2] = 1'b1;
                        for (int k = st + 2; k < total; k++) exp_data[k] = b;
                    end
                    i = st + 1;
                end else begin
                    if (st + 2 < total) exp_err[st + 2] = 1'b1;
                    r = st + 1;
                    while (!ln(r)) r++;
                    i = r + 1;
                end
            end
            for (int k = s + 2; k < r + 2 && k < total; k++) exp_busy[k] = 1'b1;
        end
    endtask

    task automatic play(input int n, input int tail, input int abort_at);
        int total;
        total = line.size() + tail;
        model_run(n, total);
        obs_busy   = new[total];
        first_evt  = -1;
        first_data = 8'h00;
        n_valid    = 0;
        n_err      = 0;
        rx_q.delete();
        @(negedge clk);
        for (int j = 0; j < total; j++) begin
            rx = ln(j);
            @(posedge clk);
            @(negedge clk);
            check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid[j]}, j);
            check("frame_err", {31'd0, frame_err}, {31'd0, exp_err[j]}, j);
            check("rx_busy", {31'd0, rx_busy}, {31'd0, exp_busy[j]}, j);
            check("rx_data", {24'd0, rx_data}, {24'd0, exp_data[j]}, j);
            check("valid_err_excl", {31'd0, rx_valid & frame_err}, 32'd0, j);
            obs_busy[j] = rx_busy;
            if ((rx_valid || frame_err) && first_evt < 0) begin
                first_evt  = j;
                first_data = rx_data;
            end
            if (rx_valid) rx_q.push_back(rx_data);
            n_valid += int'(rx_valid);
            n_err   += int'(frame_err);
            if (abort_at >= 0 && j == abort_at) return;
        end
        last_data = exp_data[total - 1];
    endtask

    typedef struct {
        bit          glitch;
        logic [15:0] cfg;
        logic [7:0]  data;
        bit          stop;
        bit          spike;
        int          hold_bits;
        int          exp_lat;
        logic [7:0]  exp_byte;
        int          exp_nv;
        int          exp_ne;
        int          busy_fall;
    } vec_t;

    localparam int LEAD = 4;

    vec_t       vecs[7];
    logic [7:0] sent_q[$];
    logic [7:0] spike_byte;
    int         n;

    initial begin
`ifdef UART_RX_MAJORITY_EN
        spike_byte = 8'h55;
`else
        spike_byte = 8'hAA;
`endif
        //            glitch cfg     data   stop  spike hold lat   byte   nv ne fall
        vecs[0] = '{1'b0, 16'd18, 8'hA5, 1'b1, 1'b0, 0,   173, 8'hA5, 1, 0, 173};
        vecs[1] = '{1'b1, 16'd18, 8'h00, 1'b1, 1'b0, 0,   -1,  8'h00, 0, 0, 11};
        vecs[2] = '{1'b0, 16'd18, 8'h3C, 1'b0, 1'b0, 100, 173, 8'hA5, 0, 1, 1982};
        vecs[3] = '{1'b0, 16'd2,  8'h81, 1'b1, 1'b0, 0,   40,  8'h81, 1, 0, 40};
        vecs[4] = '{1'b0, 16'd18, 8'h55, 1'b1, 1'b1, 0,   173, spike_byte, 1, 0, 173};
        vecs[5] = '{1'b0, 16'd7,  8'hC3, 1'b1, 1'b0, 0,   68,  8'hC3, 1, 0, 68};
        vecs[6] = '{1'b0, 16'd0,  8'h00, 1'b1, 1'b0, 0,   40,  8'h00, 1, 0, 40};

        rx        = 1'b1;
        cfg       = 16'd18;
        rstb      = 1'b0;
        last_data = 8'h00;
        #1;
        check("reset_valid", {31'd0, rx_valid}, 32'd0, 0);
        check("reset_err", {31'd0, frame_err}, 32'd0, 0);
        check("reset_busy", {31'd0, rx_busy}, 32'd0, 0);
        check("reset_data", {24'd0, rx_data}, 32'd0, 0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[v]) begin
            line.delete();
            cfg = vecs[v].cfg;
            n   = n_eff(vecs[v].cfg);
            push_bits(1'b1, LEAD);
            if (vecs[v].glitch) begin
                push_bits(1'b0, 5);
            end else begin
                add_frame(n, vecs[v].data, vecs[v].stop, vecs[v].spike);
                push_bits(1'b0, vecs[v].hold_bits * n);
            end
            play(n, 3 * n + 10, -1);
            if (vecs[v].exp_lat >= 0) begin
                check($sformatf("latency_v%0d", v), first_evt - LEAD, vecs[v].exp_lat, v);
                check($sformatf("byte_v%0d", v), {24'd0, first_data}, {24'd0, vecs[v].exp_byte}, v);
            end
            check($sformatf("n_valid_v%0d", v), n_valid, vecs[v].exp_nv, v);
            check($sformatf("n_err_v%0d", v), n_err, vecs[v].exp_ne, v);
            check($sformatf("busy_before_fall_v%0d", v),
                  {31'd0, obs_busy[LEAD + vecs[v].busy_fall - 1]}, 32'd1, v);
            check($sformatf("busy_after_fall_v%0d", v),
                  {31'd0, obs_busy[LEAD + vecs[v].busy_fall]}, 32'd0, v);
        end

        // Reset in the middle of a clamped-rate frame.
        line.delete();
        cfg = 16'd2;
        push_bits(1'b1, LEAD);
        add_frame(4, 8'h7E, 1'b1, 1'b0);
        play(4, 10, LEAD + 20);
        rstb = 1'b0;
        #1;
        check("midrst_valid", {31'd0, rx_valid}, 32'd0, 0);
        check("midrst_err", {31'd0, frame_err}, 32'd0, 0);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0, 0);
        check("midrst_data", {24'd0, rx_data}, 32'd0, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        last_data = 8'h00;
        n_valid = 0;
        n_err   = 0;
        repeat (100) begin
            @(negedge clk);
            n_valid += int'(rx_valid);
            n_err   += int'(frame_err) + int'(rx_busy);
        end
        check("midrst_no_valid", n_valid, 0, 0);
        check("midrst_no_err_busy", n_err, 0, 0);
        check("midrst_data_after", {24'd0, rx_data}, 32'd0, 0);

        // 256 random bytes back-to-back with no idle gap.
        line.delete();
        sent_q.delete();
        cfg = 16'd18;
        push_bits(1'b1, LEAD);
        for (int k = 0; k < 256; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            sent_q.push_back(b);
            add_frame(18, b, 1'b1, 1'b0);
        end
        play(18, 3 * 18 + 10, -1);
        check("b2b_count", rx_q.size(), 256, 0);
        check("b2b_err", n_err, 0, 0);
        for (int k = 0; k < 256; k++) begin
            if (k < rx_q.size()) begin
                check("b2b_data", {24'd0, rx_q[k]}, {24'd0, sent_q[k]}, k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
